// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the R0..R7 register bank: round-robin req/ack arbitration
// among NREQ writers, plus an eight-cycle sequence that zeroes every register.
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NREQ-1:0]         Req,
    input  logic [3*NREQ-1:0]       Req_dr,
    input  logic [DW*NREQ-1:0]      Req_data,
    input  logic                    Clear,
    output logic [NREQ-1:0]         Ack,
    output logic [7:0]              LD_R,
    output logic [DW-1:0]           Data_out,
    output logic [$clog2(NREQ)-1:0] Grant_id,
    output logic                    Busy
);

    localparam int GW = $clog2(NREQ);
    localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [GW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] ack_d;
    logic [7:0]      ld_d;
    logic [DW-1:0]   data_d;
    logic [GW-1:0]   gid_d;
    logic            busy_d;

    logic [NREQ-1:0] elig;
    logic [GW:0]     cand;
    logic            win_vld;
    logic [GW-1:0]   win_idx;
    logic [2:0]      win_dr;
    logic [DW-1:0]   win_data;
    logic            arb_en;

    // A requester being acked this cycle still shows its old Req; skip it.
    assign elig = Req & ~Ack;

    always_comb begin : arbitrate
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_vld && elig[cand[GW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[GW-1:0];
            end
        end
    end

    always_comb begin : winner_mux
        win_dr   = '0;
        win_data = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (win_idx == GW'(r)) begin
                win_dr   = Req_dr[3*r +: 3];
                win_data = Req_data[DW*r +: DW];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        ld_d    = '0;
        data_d  = Data_out;
        gid_d   = Grant_id;
        busy_d  = 1'b0;
        arb_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Clear) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    ld_d    = 8'h01;
                    data_d  = '0;
                    busy_d  = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                data_d = '0;
                // The edge that writes R7 also arbitrates, so a grant can follow directly.
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    arb_en  = 1'b1;
                end else begin
                    idx_d  = idx_q + 3'd1;
                    ld_d   = 8'h01 << idx_d;
                    busy_d = 1'b1;
                end
            end
        endcase

        if (arb_en && win_vld) begin
            ack_d  = NREQ'(1) << win_idx;
            ld_d   = 8'h01 << win_dr;
            data_d = win_data;
            gid_d  = win_idx;
            ptr_d  = (win_idx == GW'(NREQ-1)) ? '0 : win_idx + GW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q    <= '0;
            ptr_q    <= '0;
            Ack      <= '0;
            LD_R     <= '0;
            Data_out <= '0;
            Grant_id <= '0;
            Busy     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            Ack      <= ack_d;
            LD_R     <= ld_d;
            Data_out <= data_d;
            Grant_id <= gid_d;
            Busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of requesters, arbitration and the register bank.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int GW   = $clog2(NREQ);

    logic                 Clk = 1'b0;
    logic                 Reset_n;
    logic [NREQ-1:0]      Req;
    logic [3*NREQ-1:0]    Req_dr;
    logic [DW*NREQ-1:0]   Req_data;
    logic                 Clear;
    logic [NREQ-1:0]      Ack;
    logic [7:0]           LD_R;
    logic [DW-1:0]        Data_out;
    logic [GW-1:0]        Grant_id;
    logic                 Busy;

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .Req_dr   (Req_dr),
        .Req_data (Req_data),
        .Clear    (Clear),
        .Ack      (Ack),
        .LD_R     (LD_R),
        .Data_out (Data_out),
        .Grant_id (Grant_id),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    // register bank as driven by the DUT
    logic [DW-1:0] bank [8];
    always @(posedge Clk) begin
        for (int k = 0; k < 8; k++) begin
            if (LD_R[k]) bank[k] <= Data_out;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // requester agents: 0 = idle, 1 = waiting for grant, 2 = granted (Req still shown)
    int            ag_st   [NREQ];
    logic [2:0]    ag_dr   [NREQ];
    logic [DW-1:0] ag_data [NREQ];
    bit            auto_rq [NREQ];
    bit            rnd_mode = 1'b0;

    // reference model
    int              clear_left;
    int              ptr;
    logic [NREQ-1:0] exp_ack;
    logic [7:0]      exp_ld;
    logic [DW-1:0]   exp_data;
    logic [GW-1:0]   exp_gid;
    logic            exp_busy;
    logic [DW-1:0]   ref_rf  [8];
    bit              ref_vld [8];
    logic [NREQ-1:0] prev_ack = '0;

    task automatic issue(input int i, input logic [2:0] dr, input logic [DW-1:0] d);
        if (ag_st[i] == 0) begin
            ag_st[i]   = 1;
            ag_dr[i]   = dr;
            ag_data[i] = d;
        end
    endtask

    task automatic model_reset(input bit clear_agents);
        clear_left = 0;
        ptr        = 0;
        exp_ack    = '0;
        exp_ld     = '0;
        exp_data   = '0;
        exp_gid    = '0;
        exp_busy   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (clear_agents || ag_st[i] == 2) ag_st[i] = 0;
        end
    endtask

    task automatic model_edge();
        int win;
        if (!Reset_n) return;
        for (int k = 0; k < 8; k++) begin
            if (exp_ld[k]) begin
                ref_rf[k]  = exp_data;
                ref_vld[k] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ag_st[i] == 2) ag_st[i] = 0;
        end
        exp_ack = '0;
        if (clear_left > 1) begin
            clear_left--;
            exp_ld   = 8'h01 << (8 - clear_left);
            exp_data = '0;
            exp_busy = 1'b1;
            return;
        end
        if (clear_left == 0 && Clear) begin
            clear_left = 8;
            exp_ld     = 8'h01;
            exp_data   = '0;
            exp_busy   = 1'b1;
            return;
        end
        clear_left = 0;
        exp_busy   = 1'b0;
        exp_ld     = '0;
        win        = -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (win < 0 && ag_st[c] == 1) win = c;
        end
        if (win >= 0) begin
            exp_ld       = 8'h01 << ag_dr[win];
            exp_data     = ag_data[win];
            exp_ack[win] = 1'b1;
            exp_gid      = GW'(win);
            ptr          = (win + 1) % NREQ;
            ag_st[win]   = 2;
        end
    endtask

    task automatic stim();
        Clear = rnd_mode && ($urandom_range(0, 39) == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (ag_st[i] == 0 && (auto_rq[i] || (rnd_mode && $urandom_range(0, 2) == 0)))
                issue(i, 3'($urandom), DW'($urandom));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            Req[i]               = (ag_st[i] != 0);
            Req_dr[3*i +: 3]     = (ag_st[i] != 0) ? ag_dr[i] : 3'($urandom);
            Req_data[DW*i +: DW] = (ag_st[i] != 0) ? ag_data[i] : DW'($urandom);
        end
    endtask

    task automatic check_outputs();
        check("Ack", 32'(Ack), 32'(exp_ack));
        check("LD_R", 32'(LD_R), 32'(exp_ld));
        check("Data_out", 32'(Data_out), 32'(exp_data));
        check("Grant_id", 32'(Grant_id), 32'(exp_gid));
        check("Busy", 32'(Busy), 32'(exp_busy));
        check("LD_R_onehot0", 32'($countones(LD_R) <= 1), 32'd1);
        check("Ack_twice", 32'(Ack & prev_ack), 32'd0);
        prev_ack = Ack;
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_edge();
        #1;
        stim();
        drive();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int j = 0; j < n; j++) cycle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_Ack"}, 32'(Ack), 32'd0);
        check({tag, "_LD_R"}, 32'(LD_R), 32'd0);
        check({tag, "_Data_out"}, 32'(Data_out), 32'd0);
        check({tag, "_Grant_id"}, 32'(Grant_id), 32'd0);
        check({tag, "_Busy"}, 32'(Busy), 32'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset(1'b1);
        drive();
        cycle();
        Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        Clear   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ag_st[i]   = 0;
            auto_rq[i] = 1'b0;
            ag_dr[i]   = '0;
            ag_data[i] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            ref_rf[k]  = '0;
            ref_vld[k] = 1'b0;
        end
        model_reset(1'b1);
        drive();
        #2;
        check_zero_outputs("reset");
        cycle();
        Reset_n = 1'b1;

        // single request
        issue(1, 3'd5, 16'hBEEF);
        drive();
        cycle();
        check("single_LD_R", 32'(LD_R), 32'h20);
        check("single_Data", 32'(Data_out), 32'hBEEF);
        check("single_Ack", 32'(Ack), 32'b010);
        cycles(2);

        // round-robin fairness with all requesters re-requesting
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            auto_rq[i] = 1'b1;
            issue(i, 3'($urandom), DW'($urandom));
        end
        drive();
        cycles(12);
        for (int i = 0; i < NREQ; i++) auto_rq[i] = 1'b0;
        cycles(6);

        // one requester held continuously
        auto_rq[0] = 1'b1;
        issue(0, 3'd1, 16'h0101);
        drive();
        cycles(8);
        auto_rq[0] = 1'b0;
        cycles(3);

        // clear alongside a request
        Clear = 1'b1;
        issue(2, 3'd3, 16'h1234);
        drive();
        cycles(11);

        issue(0, 3'd6, 16'hA5A5);
        drive();
        cycles(3);

        // reset during the index-3 clear write
        Clear = 1'b1;
        issue(1, 3'd4, 16'h7777);
        drive();
        cycles(4);
        check("midclear_LD_R", 32'(LD_R), 32'h08);
        Reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset(1'b0);
        cycle();
        Reset_n = 1'b1;
        issue(0, 3'd1, 16'h0F0F);
        drive();
        cycle();
        check("post_reset_Grant_id", 32'(Grant_id), 32'd0);
        cycles(6);
        check("R6_kept", 32'(bank[6]), 32'hA5A5);

        // same-register conflict straight out of reset
        Reset_n = 1'b0;
        model_reset(1'b1);
        issue(0, 3'd2, 16'h1111);
        issue(1, 3'd2, 16'h2222);
        drive();
        cycle();
        Reset_n = 1'b1;
        cycles(5);
        check("R2_conflict", 32'(bank[2]), 32'h2222);

        // random traffic
        rnd_mode = 1'b1;
        cycles(3000);
        rnd_mode = 1'b0;
        cycles(20);
        for (int k = 0; k < 8; k++) begin
            if (ref_vld[k]) check($sformatf("R%0d_final", k), 32'(bank[k]), 32'(ref_rf[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and sequencer for the eight 16-bit general-purpose registers (R0–R7) of the simple computer. It shares the register file's single data-in bus and its per-register load strobes among several requesters using round-robin arbitration and a req/ack handshake. It also runs a clear sequence that zeroes all eight registers, one per cycle. It sits between the datapath/debug sources and the register bank and drives the bank's LD_R0..LD_R7 and Data_in directly.

## Interface
- NREQ, 3, number of requesters; legal range 2–4
- DW, 16, data width
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  NREQ  per-requester write request; level, held until Ack
- Req_dr  in  3*NREQ  destination register index; slice i belongs to requester i
- Req_data  in  DW*NREQ  write data; slice i belongs to requester i
- Clear  in  1  start the clear sequence; sampled in IDLE only
- Ack  out  NREQ  one-cycle pulse to the granted requester, coincident with its write
- LD_R  out  8  one-hot load strobes to R0..R7; bit k drives LD_Rk
- Data_out  out  DW  value to the register bank's Data_in
- Grant_id  out  $clog2(NREQ)  index of the most recent winner
- Busy  out  1  high while the clear sequence runs

## Operation
- States:
  - IDLE: arbitrate.
  - CLEAR: write zeros.
- All outputs are registered.
- Reset (Reset_n low, asynchronous, effective immediately):
  - LD_R=0, Data_out=0, Ack=0, Busy=0, Grant_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Clear index=0, state=IDLE.
  - Reset mid-clear aborts the sequence; registers not yet written keep their values.
- IDLE, Clear=1 at an edge: enter CLEAR. Clear has priority over any Req in the same cycle; pending requests stay pending.
- IDLE, no Clear, at least one eligible Req at an edge:
  - Select the first eligible requester at or after the pointer, wrapping modulo NREQ.
  - Next cycle: LD_R = onehot(Req_dr[winner]), Data_out = Req_data[winner], Ack[winner]=1, Grant_id=winner.
  - The pointer moves to winner+1 (mod NREQ).
- Eligibility: a requester whose Ack is high in the current cycle is excluded from the arbitration at the end of that cycle, because its Req is stale.
  - Consequence: one requester gets at most one write every 2 cycles.
  - Different requesters can be granted in back-to-back cycles.
- IDLE, no eligible Req: LD_R=0, Ack=0; Data_out holds its last value.
- CLEAR:
  - For 8 consecutive cycles, LD_R = onehot(index), Data_out=0, Busy=1, Ack=0.
  - index runs 0..7, then wraps to 0.
  - After the index-7 cycle, return to IDLE with Busy=0.
  - Clear is ignored while in CLEAR.
- Multiple requests to the same register are serialized; the later grant's data is what remains.
- LD_R is never more than one-hot.
- Req_dr and Req_data of a non-granted requester have no effect.

## Timing
- Request latency: Req sampled at edge E → LD_R/Ack/Data_out high in the cycle after E → register bank captures at edge E+1.
- The requester must hold Req, Req_dr and Req_data stable until it sees Ack. It drops or replaces Req in the cycle after Ack.
- Clear latency: Clear sampled at edge E → R0 written at E+1 … R7 written at E+8. Busy is high for exactly 8 cycles.
- First grant after the clear sequence can appear in the cycle following the last clear write (arbitration at the edge where index 7 is written).
- Worst-case wait for a continuously requesting requester: NREQ−1 grants, or 8 cycles plus NREQ−1 grants if a clear intervenes.

## Test plan
- Reset release, single request:
  - Reset_n low: all outputs 0.
  - Release, then Req[1]=1, Req_dr[1]=5, Req_data[1]=16'hBEEF.
  - Next cycle: LD_R=8'b0010_0000, Data_out=16'hBEEF, Ack=3'b010, Grant_id=1, all for exactly 1 cycle.
- Round-robin fairness:
  - Req=3'b111 held, each requester re-requesting after its Ack.
  - Ack sequence is 0,1,2,0,1,2 in consecutive cycles.
  - No requester gets Ack on two consecutive cycles.
- Back-to-back same requester:
  - Only Req[0] held continuously.
  - Ack[0] toggles 1,0,1,0; one write every 2 cycles.
- Clear sequence:
  - Clear=1 together with Req[2]=1.
  - Busy high for 8 cycles; LD_R walks 01,02,…,80 with Data_out=0 and no Ack.
  - Then Ack[2] with its write in the following cycle.
- Reset mid-clear:
  - Reset_n low during the index-3 cycle.
  - Outputs go to 0 immediately (asynchronously); state returns to IDLE.
  - After release, Busy=0 and a pending Req is granted normally, starting with requester 0 priority.
- Same-register conflict:
  - Req[0] (dr=2, 16'h1111) and Req[1] (dr=2, 16'h2222) raised together from reset.
  - Writes occur in order 0 then 1; R2 ends at 16'h2222.
